// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory stage: accepts one load/store at a time,
// waits LATENCY cycles, then issues a single-cycle response with extended load data.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int unsigned AddrW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CntInit  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        enter_resp;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY=0 the response is formed at the acceptance edge, so the
    // live request stands in for the not-yet-latched one.
    logic [31:0] eff_addr, eff_wdata;
    logic        eff_we;
    logic [2:0]  eff_ctrl;
    logic        eff_err;
    logic [AddrW-1:0] word_idx;
    logic [31:0] cur_word, load_data, merged, wsh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be;

    // Select request source and decode legality, load extraction and store merge.
    always_comb begin
        eff_addr  = (state_q == StIdle) ? req_addr  : addr_q;
        eff_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
        eff_we    = (state_q == StIdle) ? req_we    : we_q;
        eff_ctrl  = (state_q == StIdle) ? req_ctrl  : ctrl_q;

        eff_err = (eff_ctrl == 3'b011) || (eff_ctrl == 3'b110) || (eff_ctrl == 3'b111)
               || ((eff_ctrl[1:0] == 2'b01) && eff_addr[0])
               || ((eff_ctrl[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00))
               || ({1'b0, eff_addr} >= MemBytes);

        word_idx = eff_addr[AddrW+1:2];
        cur_word = mem[word_idx];
        byte_sel = 8'(cur_word >> {eff_addr[1:0], 3'b000});
        half_sel = eff_addr[1] ? cur_word[31:16] : cur_word[15:0];

        load_data = 32'd0;
        case (eff_ctrl)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = cur_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase

        be  = 4'b1111;
        wsh = eff_wdata;
        case (eff_ctrl[1:0])
            2'b00: begin
                be  = 4'b0001 << eff_addr[1:0];
                wsh = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                be  = eff_addr[1] ? 4'b1100 : 4'b0011;
                wsh = {2{eff_wdata[15:0]}};
            end
            default: begin
                be  = 4'b1111;
                wsh = eff_wdata;
            end
        endcase

        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wsh[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    // FSM next state, wait counter and request latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        ctrl_d     = ctrl_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    ctrl_d  = req_ctrl;
                    if (LATENCY > 0) begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response data is captured at the edge entering RESP and held afterwards.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = eff_err;
            rdata_d = (eff_err || eff_we) ? 32'd0 : load_data;
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            ctrl_q  <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory array is never reset; a reset on the RESP-entry edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && eff_we && !eff_err) begin
            mem[word_idx] <= merged;
        end
    end

    // Handshake and response outputs.
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        stall     = ((state_q == StIdle) && req_valid) || (state_q == StWait);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-level memory model.
module tb_data_mem_responder;

    localparam int unsigned Lat = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_err, stall;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_ctrl;

    logic        z_valid, z_ready, z_we, z_rsp_valid, z_err, z_stall;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [2:0]  z_ctrl;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(Lat)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_we(z_we), .req_ctrl(z_ctrl),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err), .stall(z_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access of 1/2/4 bytes starting at byte offset addr%4 of word addr/4.
    function automatic void model(input logic we, input logic [2:0] ctrl,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int unsigned nb, off;
        logic [31:0] w, v;
        nb    = 1 << ctrl[1:0];
        off   = addr % 4;
        err   = (ctrl == 3'd3) || (ctrl == 3'd6) || (ctrl == 3'd7)
             || (nb == 2 && addr[0]) || (nb == 4 && off != 0) || (addr >= 32'd1024);
        rdata = 32'd0;
        if (err) return;
        w = ref_mem[addr / 4];
        if (we) begin
            for (int i = 0; i < int'(nb); i++) w[8*(int'(off)+i) +: 8] = wdata[8*i +: 8];
            ref_mem[addr / 4] = w;
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = w[8*(int'(off)+i) +: 8];
            if (!ctrl[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rdata = v;
        end
    endfunction

    // One full transaction on the LATENCY=2 instance, starting and ending in IDLE.
    task automatic xact(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got,
                        output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rd;
        model(we, ctrl, addr, wdata, exp_err, exp_rd);
        req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        #1;
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        check_eq("stall_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom; req_we = 1'($urandom); req_ctrl = 3'($urandom);
        for (int i = 1; i <= int'(Lat); i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            #1;
            check_eq("wait_valid", 32'(rsp_valid), 32'd0);
            check_eq("wait_stall", 32'(stall), 32'd1);
            check_eq("wait_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'($urandom);
        #1;
        check_eq("resp_valid", 32'(rsp_valid), 32'd1);
        check_eq("resp_stall", 32'(stall), 32'd0);
        check_eq("resp_ready", 32'(req_ready), 32'd0);
        check_eq("resp_err", 32'(rsp_err), 32'(exp_err));
        check_eq("resp_rdata", rsp_rdata, exp_rd);
        got     = rsp_rdata;
        got_err = rsp_err;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check_eq("idle_valid", 32'(rsp_valid), 32'd0);
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        check_eq("idle_stall", 32'(stall), 32'd0);
        check_eq("hold_rdata", rsp_rdata, exp_rd);
    endtask

    // Three aligned word accesses with req_valid held high on the LATENCY=0 instance.
    task automatic z_burst(input logic we, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2);
        logic [31:0] d [3];
        d = '{d0, d1, d2};
        z_valid = 1'b1; z_we = we; z_ctrl = 3'b010;
        for (int i = 0; i < 3; i++) begin
            z_addr = 32'(i * 4); z_wdata = d[i];
            #1;
            check_eq("z_idle_ready", 32'(z_ready), 32'd1);
            check_eq("z_idle_stall", 32'(z_stall), 32'd1);
            check_eq("z_idle_valid", 32'(z_rsp_valid), 32'd0);
            @(negedge clk); #1;
            check_eq("z_resp_valid", 32'(z_rsp_valid), 32'd1);
            check_eq("z_resp_ready", 32'(z_ready), 32'd0);
            check_eq("z_resp_stall", 32'(z_stall), 32'd0);
            check_eq("z_resp_err", 32'(z_err), 32'd0);
            check_eq("z_resp_rdata", z_rdata, we ? 32'd0 : d[i]);
            @(negedge clk);
        end
        z_valid = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] got, a, zd0, zd1, zd2;
        logic        gerr;
        logic [2:0]  c;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_ctrl = '0;
        z_valid = 1'b0; z_addr = '0; z_wdata = '0; z_we = 1'b0; z_ctrl = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);

        // Fill memory so every later load has a defined expectation.
        for (int w = 0; w < 256; w++) xact(1'b1, 3'b010, 32'(w * 4), $urandom, got, gerr);

        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, gerr);
        check_eq("sw10_err", 32'(gerr), 32'd0);
        xact(1'b0, 3'b010, 32'h10, 32'd0, got, gerr);
        check_eq("lw10", got, 32'hDEADBEEF);
        xact(1'b0, 3'b000, 32'h13, 32'd0, got, gerr);
        check_eq("lb13", got, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 32'h13, 32'd0, got, gerr);
        check_eq("lbu13", got, 32'h000000DE);
        xact(1'b0, 3'b001, 32'h12, 32'd0, got, gerr);
        check_eq("lh12", got, 32'hFFFFDEAD);
        xact(1'b0, 3'b101, 32'h10, 32'd0, got, gerr);
        check_eq("lhu10", got, 32'h0000BEEF);
        xact(1'b1, 3'b000, 32'h11, 32'h000000AA, got, gerr);
        xact(1'b0, 3'b010, 32'h10, 32'd0, got, gerr);
        check_eq("lw10_sb", got, 32'hDEADAAEF);

        xact(1'b0, 3'b010, 32'h12, 32'd0, got, gerr);
        check_eq("lw12_err", 32'(gerr), 32'd1);
        xact(1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, got, gerr);
        check_eq("sh21_err", 32'(gerr), 32'd1);
        xact(1'b0, 3'b010, 32'h20, 32'd0, got, gerr);
        check_eq("lw20_kept", got, ref_mem[8]);
        xact(1'b0, 3'b010, 32'h400, 32'd0, got, gerr);
        check_eq("lw400_err", 32'(gerr), 32'd1);
        xact(1'b1, 3'b011, 32'h10, 32'h0, got, gerr);
        check_eq("ctrl011_err", 32'(gerr), 32'd1);
        xact(1'b0, 3'b010, 32'h10, 32'd0, got, gerr);
        check_eq("lw10_kept", got, 32'hDEADAAEF);

        // Reset during WAIT, including the edge that would enter RESP: store must vanish.
        for (int rc = 1; rc <= int'(Lat); rc++) begin
            req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010;
            req_addr = 32'h20; req_wdata = 32'h12345678;
            @(posedge clk); #1;
            req_valid = 1'b0;
            repeat (rc) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check_eq("rstw_ready", 32'(req_ready), 32'd1);
            check_eq("rstw_rdata", rsp_rdata, 32'd0);
            check_eq("rstw_err", 32'(rsp_err), 32'd0);
            for (int k = 0; k < int'(Lat) + 2; k++) begin
                check_eq("rstw_novalid", 32'(rsp_valid), 32'd0);
                @(negedge clk); #1;
            end
            xact(1'b0, 3'b010, 32'h20, 32'd0, got, gerr);
            check_eq("rstw_lw20", got, ref_mem[8]);
        end

        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0) a = $urandom_range(1024, 1100);
            c = 3'($urandom);
            xact(1'($urandom), c, a, $urandom, got, gerr);
        end

        zd0 = $urandom; zd1 = $urandom; zd2 = $urandom;
        z_burst(1'b1, zd0, zd1, zd2);
        z_burst(1'b0, zd0, zd1, zd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit memory words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between acceptance and the response cycle (range 0..15).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 req_valid  input  1  memory-stage request present.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_addr  input  32  byte address (ALU result from the memory stage).
REQ-009 req_wdata  input  32  store data (rs2 value from the memory stage).
REQ-010 req_we  input  1  1 = store, 0 = load (DMWr).
REQ-011 req_ctrl  input  3  access type (DMCtrl, RISC-V funct3): 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  extended load data.
REQ-014 rsp_err  output  1  request rejected (misaligned, out of range, or illegal ctrl).
REQ-015 stall  output  1  pipeline must hold the fetch, decode, execute and memory registers.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready at a rising edge, which latches addr, wdata, we and ctrl.
REQ-018 On acceptance, the FSM SHALL go IDLE->WAIT with counter=LATENCY-1 if LATENCY>0, else IDLE->RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; WAIT->RESP at the edge where counter==0.
REQ-020 RESP SHALL last exactly one cycle with rsp_valid=1, then RESP->IDLE unconditionally; no request is accepted during RESP.
REQ-021 rsp_valid SHALL assert in the (LATENCY+1)th cycle after the acceptance edge.
REQ-022 stall SHALL = (IDLE && req_valid) || WAIT; stall SHALL be 0 in RESP and in IDLE without req_valid.
REQ-023 Stores and load sampling SHALL occur at the edge entering RESP, using the latched request.
REQ-024 Error conditions: ctrl in {011,110,111}; half access with addr[0]=1; word access with addr[1:0]!=0; addr >= DEPTH_WORDS*4. Any error SHALL give rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-025 Store lanes: SB writes byte lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes; other bytes are unchanged.
REQ-026 Loads: byte/half SHALL be sign-extended for 000/001 and zero-extended for 100/101; word is passed unchanged.
REQ-027 A store response SHALL give rsp_rdata=0 and rsp_err=0 if legal.
REQ-028 Outside RESP, rsp_rdata and rsp_err SHALL hold their last values; consumers sample them only with rsp_valid.
REQ-029 Back-to-back requests: the earliest next acceptance SHALL be the cycle after RESP (IDLE), giving a throughput of one request per LATENCY+2 cycles.
REQ-030 Changes on req_* inputs after acceptance SHALL have no effect on the in-flight request.

Reset
REQ-031 While rst=1 at an edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 rst SHALL have priority over all transitions; if rst=1 at the edge that would enter RESP, the pending store is dropped (no write) and no response is issued.
REQ-034 The cycle after rst deasserts, req_ready SHALL be 1.

Verification
REQ-035 LATENCY=2: SW addr=0x10, wdata=0xDEADBEEF accepted at edge 0 -> stall=1 for 3 cycles (IDLE+2 WAIT), rsp_valid=1 in cycle 3, rsp_err=0; then LW 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-036 After REQ-035: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-037 SB addr=0x11, wdata=0x000000AA over 0xDEADBEEF, then LW 0x10 -> 0xDEADAABF... correction: byte lane 1 replaced -> 0xDEADAAEF.
REQ-038 LW 0x12 (misaligned), SH 0x21 (misaligned), LW 0x400 (out of range, DEPTH_WORDS=256) and ctrl=011 -> each gives rsp_err=1 and rsp_rdata=0; a following LW at the same aligned word shows unchanged data.
REQ-039 SW 0x20=0x12345678 accepted, rst pulsed during WAIT -> no rsp_valid, req_ready=1 the cycle after reset, LW 0x20 returns the prior value.
REQ-040 LATENCY=0: req_valid held high with 3 successive loads -> rsp_valid in cycles 1, 3 and 5, req_ready=0 in each RESP cycle, stall=1 in cycles 0, 2 and 4.
